// File: rtl/cpt_pkg.sv
// Shared types and default sizing for the round-robin phase-counter scheduler.
package cpt_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned SLOT_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        GAP  = 2'b10
    } state_e;

endpackage

// File: rtl/cpt_rr_sched_if.sv
// Requester <-> scheduler bundle; the done vector exists only with CPT_SCHED_DONE_EN.
interface cpt_rr_sched_if #(
    parameter int unsigned NREQ = cpt_pkg::NREQ_DEFAULT,
    parameter int unsigned SLOT = cpt_pkg::SLOT_DEFAULT
) ();
    localparam int unsigned OW = $clog2(NREQ);

    logic [NREQ-1:0] req;
`ifdef CPT_SCHED_DONE_EN
    logic [NREQ-1:0] done;
`endif
    logic [NREQ-1:0] grant;
    logic [OW-1:0]   owner;
    logic            activate;
    logic [SLOT-1:0] phase;
    logic            busy;

`ifdef CPT_SCHED_DONE_EN
    modport master (output req, done, input grant, owner, activate, phase, busy);
    modport slave  (input req, done, output grant, owner, activate, phase, busy);
`else
    modport master (output req, input grant, owner, activate, phase, busy);
    modport slave  (input req, output grant, owner, activate, phase, busy);
`endif

endinterface

// File: rtl/cpt_rr_sched_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    localparam int unsigned OW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   last,
    output logic            found_c,
    output logic [OW-1:0]   idx_c
);

    always_comb begin
        logic [OW-1:0] cand;
        found_c = 1'b0;
        idx_c   = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = OW'((32'(last) + i) % NREQ);
            if (!found_c && req[cand]) begin
                found_c = 1'b1;
                idx_c   = cand;
            end
        end
    end

endmodule

// File: rtl/cpt_rr_sched.sv
// Round-robin owner of the shared one-hot phase counter; IDLE/RUN/GAP FSM with registered outputs.
// Optional early release through the done vector when CPT_SCHED_DONE_EN is defined.
module cpt_rr_sched
    import cpt_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned SLOT = SLOT_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    cpt_rr_sched_if.slave  bus
);

    localparam int unsigned OW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [OW-1:0]   last_q, last_d;
    logic [NREQ-1:0] grant_d;
    logic [OW-1:0]   owner_d;
    logic [SLOT-1:0] phase_d;
    logic            activate_d;
    logic            busy_d;
    logic            found_c;
    logic [OW-1:0]   win_c;
    logic            end_c;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req),
        .last    (last_q),
        .found_c (found_c),
        .idx_c   (win_c)
    );

    // Slot terminates on last phase or owner withdrawal; other requesters are ignored.
    always_comb begin
        end_c = bus.phase[SLOT-1] | ~bus.req[bus.owner];
`ifdef CPT_SCHED_DONE_EN
        end_c = end_c | bus.done[bus.owner];
`endif
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = '0;
        owner_d    = '0;
        phase_d    = '0;
        activate_d = 1'b0;
        busy_d     = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (found_c) begin
                    state_d    = RUN;
                    last_d     = win_c;
                    grant_d    = NREQ'(1) << win_c;
                    owner_d    = win_c;
                    phase_d    = SLOT'(1);
                    activate_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (end_c) begin
                    state_d = GAP;
                end else begin
                    grant_d    = bus.grant;
                    owner_d    = bus.owner;
                    phase_d    = {bus.phase[SLOT-2:0], 1'b0};
                    activate_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_q       <= OW'(NREQ - 1);
            bus.grant    <= '0;
            bus.owner    <= '0;
            bus.phase    <= '0;
            bus.activate <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            bus.grant    <= grant_d;
            bus.owner    <= owner_d;
            bus.phase    <= phase_d;
            bus.activate <= activate_d;
            bus.busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_cpt_rr_sched.sv
// Randomized bench for cpt_rr_sched against a slot-level round-robin reference model.
module tb_cpt_rr_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned SLOT = 3;

    logic clk = 1'b0;
    logic reset;

    cpt_rr_sched_if #(.NREQ(NREQ), .SLOT(SLOT)) bus ();

    cpt_rr_sched #(.NREQ(NREQ), .SLOT(SLOT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: who owns the counter and how many steps of the slot have been used.
    int m_owner;
    int m_step;
    int m_last;
    bit m_gap;

    function automatic void m_reset();
        m_owner = -1;
        m_step  = 0;
        m_last  = NREQ - 1;
        m_gap   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        if (m_owner >= 0) begin
            if (m_step == SLOT || !r[m_owner] || d[m_owner]) begin
                m_owner = -1;
                m_step  = 0;
                m_gap   = 1'b1;
            end else begin
                m_step++;
            end
        end else begin
            m_gap = 1'b0;
            for (int w = 1; w <= NREQ; w++) begin
                int k;
                k = (m_last + w) % NREQ;
                if (m_owner < 0 && r[k]) begin
                    m_owner = k;
                    m_step  = 1;
                    m_last  = k;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        logic [31:0] eg, eo, ep;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        eo = (m_owner >= 0) ? 32'(m_owner) : 32'd0;
        ep = (m_owner >= 0) ? (32'd1 << (m_step - 1)) : 32'd0;
        chk("grant",    32'(bus.grant),    eg);
        chk("owner",    32'(bus.owner),    eo);
        chk("phase",    32'(bus.phase),    ep);
        chk("activate", 32'(bus.activate), 32'(m_owner >= 0));
        chk("busy",     32'(bus.busy),     32'((m_owner >= 0) || m_gap));
    endtask

    task automatic tick();
        logic [NREQ-1:0] d;
        d = '0;
        @(posedge clk);
`ifdef CPT_SCHED_DONE_EN
        d = bus.done;
`endif
        if (reset) model_edge(bus.req, d);
        else m_reset();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_done(input logic [NREQ-1:0] d);
`ifdef CPT_SCHED_DONE_EN
        bus.done = d;
`else
        d = '0;
`endif
    endtask

    task automatic wait_for(input string tag, input logic [NREQ-1:0] g, input logic [SLOT-1:0] p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            if (bus.grant == g && bus.phase == p) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        bus.req = '0;
        set_done('0);
        m_reset();

        repeat (3) @(negedge clk);
        check_outputs();
        reset = 1'b1;
        repeat (10) tick();

        bus.req = 4'b0001;
        repeat (12) tick();

        bus.req = 4'b1111;
        repeat (20) tick();

        // Owner 2 withdraws mid-slot; requester 3 is next in line.
        wait_for("wait_own2", 4'b0100, 3'b010);
        bus.req = 4'b1011;
        tick();
        chk("drop_grant", 32'(bus.grant), 32'h0);
        chk("drop_phase", 32'(bus.phase), 32'h0);
        tick();
        chk("after_drop", 32'(bus.grant), 32'h8);
        bus.req = 4'b1111;

`ifdef CPT_SCHED_DONE_EN
        wait_for("wait_own1", 4'b0010, 3'b001);
        set_done(4'b0010);
        tick();
        chk("done_own", 32'(bus.grant), 32'h0);
        set_done('0);
        wait_for("wait_own2b", 4'b0100, 3'b001);
        set_done(4'b1000);
        tick();
        chk("done_other", 32'(bus.grant), 32'h4);
        set_done('0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [NREQ-1:0] r;
            r = bus.req;
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            bus.req = r;
            if ($urandom_range(0, 7) == 0) set_done(NREQ'($urandom()));
            else set_done('0);
            tick();
        end
        set_done('0);

        // Asynchronous reset in the middle of a slot.
        bus.req = 4'b1111;
        wait_for("wait_mid", bus.grant | 4'b0001, 3'b010);
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk("rst_grant",    32'(bus.grant),    32'h0);
        chk("rst_phase",    32'(bus.phase),    32'h0);
        chk("rst_activate", 32'(bus.activate), 32'h0);
        chk("rst_busy",     32'(bus.busy),     32'h0);
        @(negedge clk);
        bus.req = 4'b1001;
        tick();
        reset = 1'b1;
        tick();
        chk("first_after_rst", 32'(bus.grant), 32'h1);
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
